// File: rtl/program_encoder_pkg.sv
// Shared ARMAria encoding constants: instruction IDs, opcodes and condition codes,
// plus the encoder session state type.
package program_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FULL,
    ST_DONE,
    ST_ERROR
  } enc_state_t;

  localparam int unsigned ID_LSL            = 1;
  localparam int unsigned ID_LSR            = 2;
  localparam int unsigned ID_ASR            = 3;
  localparam int unsigned ID_ADDSUB_FIRST   = 4;
  localparam int unsigned ID_ADDSUB_LAST    = 7;
  localparam int unsigned ID_IMM8_FIRST     = 8;
  localparam int unsigned ID_IMM8_LAST      = 11;
  localparam int unsigned ID_ALU_FIRST      = 12;
  localparam int unsigned ID_ALU_LAST       = 27;
  localparam int unsigned ID_HI4_FIRST      = 28;
  localparam int unsigned ID_HI4_LAST       = 30;
  localparam int unsigned ID_HI5_FIRST      = 31;
  localparam int unsigned ID_HI5_LAST       = 33;
  localparam int unsigned ID_HI6_FIRST      = 34;
  localparam int unsigned ID_HI6_LAST       = 37;
  localparam int unsigned ID_BX             = 38;
  localparam int unsigned ID_ADR            = 39;
  localparam int unsigned ID_LDST_REG_FIRST = 40;
  localparam int unsigned ID_LDST_REG_LAST  = 47;
  localparam int unsigned ID_LDST_IMM_FIRST = 48;
  localparam int unsigned ID_LDST_IMM_LAST  = 53;
  localparam int unsigned ID_LDST_SP_FIRST  = 54;
  localparam int unsigned ID_LDST_SP_LAST   = 57;
  localparam int unsigned ID_NOP            = 58;
  localparam int unsigned ID_EXT_FIRST      = 59;
  localparam int unsigned ID_EXT_LAST       = 62;
  localparam int unsigned ID_REV_FIRST      = 63;
  localparam int unsigned ID_REV_LAST       = 66;
  localparam int unsigned ID_PUSH           = 67;
  localparam int unsigned ID_POP            = 68;
  localparam int unsigned ID_SYS_REG        = 69;
  localparam int unsigned ID_SYS_HALT       = 70;
  localparam int unsigned ID_SYS_RET        = 71;
  localparam int unsigned ID_MULTI          = 72;
  localparam int unsigned ID_BCOND          = 73;
  localparam int unsigned ID_B              = 74;
  localparam int unsigned ID_BL             = 75;
  localparam int unsigned ID_BX_ALWAYS      = 76;
  localparam int unsigned ID_RESET          = 100;

  localparam logic [3:0] OP_SHIFT      = 4'h0;
  localparam logic [3:0] OP_ADDSUB     = 4'h1;
  localparam logic [3:0] OP_MOV        = 4'h2;
  localparam logic [3:0] OP_CMP        = 4'h3;
  localparam logic [3:0] OP_ALU        = 4'h4;
  localparam logic [3:0] OP_LDST_REG   = 4'h5;
  localparam logic [3:0] OP_LDST_IMM   = 4'h6;
  localparam logic [3:0] OP_LDST_SP_LO = 4'h9;
  localparam logic [3:0] OP_LDST_SP_HI = 4'hA;
  localparam logic [3:0] OP_MISC       = 4'hB;
  localparam logic [3:0] OP_MULTI      = 4'hC;
  localparam logic [3:0] OP_BCOND      = 4'hD;
  localparam logic [3:0] OP_BRANCH     = 4'hE;
  localparam logic [3:0] OP_SYSTEM     = 4'hF;

  localparam logic [3:0] COND_ALWAYS   = 4'hE;

endpackage

// File: rtl/instruction_field_encoder.sv
// Combinational encoder: decoded instruction fields -> 16-bit ARMAria word plus
// a flag telling whether the ID has an encoding at all.
module instruction_field_encoder
  import program_encoder_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH      = 16,
  parameter int unsigned ID_WIDTH               = 7,
  parameter int unsigned REGISTER_WIDTH         = 4,
  parameter int unsigned OFFSET_WIDTH           = 12,
  parameter int unsigned BRANCH_CONDITION_WIDTH = 5
) (
  input  logic [ID_WIDTH-1:0]               id,
  input  logic [REGISTER_WIDTH-1:0]         reg_d,
  input  logic [REGISTER_WIDTH-1:0]         reg_a,
  input  logic [REGISTER_WIDTH-1:0]         reg_b,
  input  logic [OFFSET_WIDTH-1:0]           offset,
  input  logic [BRANCH_CONDITION_WIDTH-1:0] cond,
  output logic [INSTRUCTION_WIDTH-1:0]      word,
  output logic                              valid
);

  logic [2:0]          d, a, b;
  logic [ID_WIDTH-1:0] rel;
  logic [3:0]          op;
  int unsigned         id_n;
  logic                unused_fields;

  assign d = reg_d[2:0];
  assign a = reg_a[2:0];
  assign b = reg_b[2:0];
  // Out-of-range field bits are truncated by design.
  assign unused_fields = ^{reg_d[REGISTER_WIDTH-1:3], reg_a[REGISTER_WIDTH-1:3],
                           reg_b[REGISTER_WIDTH-1:3], offset[OFFSET_WIDTH-1:8],
                           cond[BRANCH_CONDITION_WIDTH-1:4]};

  always_comb begin
    word  = '0;
    valid = 1'b1;
    rel   = '0;
    op    = '0;
    id_n  = 32'(id);
    case (id_n) inside
      [ID_LSL:ID_ASR]:
        word = {(id_n == ID_ASR) ? OP_ADDSUB : OP_SHIFT, id_n == ID_LSR, offset[4:0], a, d};
      [ID_ADDSUB_FIRST:ID_ADDSUB_LAST]:
        word = {OP_ADDSUB, 1'b1, id[1:0], id[1] ? offset[2:0] : b, a, d};
      [ID_IMM8_FIRST:ID_IMM8_LAST]:
        word = {id[1] ? OP_CMP : OP_MOV, id[0], d, offset[7:0]};
      [ID_ALU_FIRST:ID_ALU_LAST]: begin
        rel  = id - ID_WIDTH'(ID_ALU_FIRST);
        word = {OP_ALU, rel[5:2], rel[1:0], b, d};
      end
      [ID_HI4_FIRST:ID_HI4_LAST]: begin
        rel  = id - ID_WIDTH'(ID_HI4_FIRST - 1);
        word = {OP_ALU, 4'h4, rel[1:0], b, d};
      end
      [ID_HI5_FIRST:ID_HI5_LAST]: begin
        rel  = id - ID_WIDTH'(ID_HI5_FIRST - 1);
        word = {OP_ALU, 4'h5, rel[1:0], b, d};
      end
      [ID_HI6_FIRST:ID_HI6_LAST]: begin
        rel  = id - ID_WIDTH'(ID_HI6_FIRST);
        word = {OP_ALU, 4'h6, rel[1:0], b, d};
      end
      ID_BX, ID_BX_ALWAYS:
        word = {OP_ALU, 4'h7, (id_n == ID_BX) ? cond[3:0] : 4'hF, 1'b0, b};
      ID_ADR:
        word = {OP_ALU, 1'b1, d, offset[7:0]};
      [ID_LDST_REG_FIRST:ID_LDST_REG_LAST]: begin
        rel  = id - ID_WIDTH'(ID_LDST_REG_FIRST);
        word = {OP_LDST_REG, rel[2:0], b, a, d};
      end
      [ID_LDST_IMM_FIRST:ID_LDST_IMM_LAST]: begin
        rel  = id - ID_WIDTH'(ID_LDST_IMM_FIRST);
        op   = OP_LDST_IMM + {2'b00, rel[2:1]};
        word = {op, id[0], offset[4:0], a, d};
      end
      [ID_LDST_SP_FIRST:ID_LDST_SP_LAST]: begin
        rel  = id - ID_WIDTH'(ID_LDST_SP_FIRST);
        word = {rel[1] ? OP_LDST_SP_HI : OP_LDST_SP_LO, id[0], d, offset[7:0]};
      end
      ID_NOP:
        word = {OP_MISC, 12'h000};
      [ID_EXT_FIRST:ID_EXT_LAST]: begin
        rel  = id - ID_WIDTH'(ID_EXT_FIRST);
        word = {OP_MISC, 4'h2, rel[1:0], b, d};
      end
      [ID_REV_FIRST:ID_REV_LAST]: begin
        rel  = id - ID_WIDTH'(ID_REV_FIRST);
        word = {OP_MISC, 4'hA, rel[1:0], b, d};
      end
      ID_PUSH:     word = {OP_MISC, 4'h4, 5'b00000, d};
      ID_POP:      word = {OP_MISC, 4'hD, 5'b00000, d};
      ID_SYS_REG:  word = {OP_MISC, 4'hE, 5'b00000, d};
      ID_SYS_HALT: word = {OP_MISC, 4'hE, 8'h40};
      ID_SYS_RET:  word = {OP_MISC, 4'hE, 5'b10000, d};
      ID_MULTI:    word = {OP_MULTI, 12'h000};
      ID_BCOND:    word = {OP_BCOND, cond[3:0], offset[7:0]};
      ID_B:        word = {OP_BRANCH, 12'h000};
      ID_BL:       word = {OP_BRANCH, 12'h800};
      ID_RESET:    word = {OP_SYSTEM, 12'hFFF};
      default:     valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/program_encoder.sv
// Program writer: accepts decoded field bundles, encodes them and streams the
// words to consecutive instruction-memory addresses within a start/finish session.
module program_encoder
  import program_encoder_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH      = 16,
  parameter int unsigned ID_WIDTH               = 7,
  parameter int unsigned REGISTER_WIDTH         = 4,
  parameter int unsigned OFFSET_WIDTH           = 12,
  parameter int unsigned BRANCH_CONDITION_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH             = 11
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic                              finish,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ID_WIDTH-1:0]               ID,
  input  logic [REGISTER_WIDTH-1:0]         RegD,
  input  logic [REGISTER_WIDTH-1:0]         RegA,
  input  logic [REGISTER_WIDTH-1:0]         RegB,
  input  logic [OFFSET_WIDTH-1:0]           Offset,
  input  logic [BRANCH_CONDITION_WIDTH-1:0] branch_condition,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0]      mem_data,
  output logic [ADDR_WIDTH:0]               word_count,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  enc_state_t                   state, nxt;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [INSTRUCTION_WIDTH-1:0] enc_word;
  logic                         enc_valid;
  logic                         accept, write_en;

  instruction_field_encoder #(
    .INSTRUCTION_WIDTH      (INSTRUCTION_WIDTH),
    .ID_WIDTH               (ID_WIDTH),
    .REGISTER_WIDTH         (REGISTER_WIDTH),
    .OFFSET_WIDTH           (OFFSET_WIDTH),
    .BRANCH_CONDITION_WIDTH (BRANCH_CONDITION_WIDTH)
  ) u_field_encoder (
    .id     (ID),
    .reg_d  (RegD),
    .reg_a  (RegA),
    .reg_b  (RegB),
    .offset (Offset),
    .cond   (branch_condition),
    .word   (enc_word),
    .valid  (enc_valid)
  );

  // A restart request discards any bundle offered in the same cycle.
  assign accept   = in_valid & in_ready & ~start;
  assign write_en = accept & enc_valid;

  always_comb begin
    nxt = state;
    if (start) begin
      nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept && !enc_valid)             nxt = ST_ERROR;
          else if (finish)                      nxt = ST_DONE;
          else if (write_en && wr_addr == '1)   nxt = ST_FULL;
        end
        ST_FULL: if (finish) nxt = ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      word_count <= '0;
      wr_addr    <= '0;
    end else begin
      state    <= nxt;
      in_ready <= (nxt == ST_RUN);
      busy     <= (nxt == ST_RUN) || (nxt == ST_FULL);
      done     <= (nxt == ST_DONE);
      error    <= (nxt == ST_ERROR);
      mem_we   <= write_en;
      if (start) begin
        wr_addr    <= base_addr;
        word_count <= '0;
      end else if (write_en) begin
        mem_addr   <= wr_addr;
        mem_data   <= enc_word;
        wr_addr    <= wr_addr + ADDR_WIDTH'(1);
        word_count <= word_count + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_encoder.sv
// Directed bench for program_encoder: expected writes are queued when a bundle is
// offered and compared when the memory write strobe appears.
module tb_program_encoder;
  import program_encoder_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic        finish = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  ID = '0;
  logic [3:0]  RegD = '0, RegA = '0, RegB = '0;
  logic [11:0] Offset = '0;
  logic [4:0]  branch_condition = '0;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_data;
  logic [11:0] word_count;
  logic        busy, done, error;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
    logic [11:0] count;
  } wr_t;

  wr_t         sb[$];
  logic [10:0] exp_addr = '0;
  logic [11:0] exp_count = '0;
  int          checks = 0;
  int          errors = 0;

  program_encoder #(
    .ADDR_WIDTH (11)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .finish           (finish),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .ID               (ID),
    .RegD             (RegD),
    .RegA             (RegA),
    .RegB             (RegB),
    .Offset           (Offset),
    .branch_condition (branch_condition),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .word_count       (word_count),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference written straight from the encoding table.
  function automatic logic [16:0] ref_enc(input int id, input logic [3:0] rd, ra, rb,
                                          input logic [11:0] off, input logic [4:0] c);
    logic [2:0] d, a, b;
    logic [15:0] w;
    logic v;
    d = rd[2:0]; a = ra[2:0]; b = rb[2:0]; v = 1'b1; w = '0;
    if (id == 1 || id == 2)        w = {4'h0, (id == 2) ? 1'b1 : 1'b0, off[4:0], a, d};
    else if (id == 3)              w = {4'h1, 1'b0, off[4:0], a, d};
    else if (id >= 4 && id <= 7)   w = {4'h1, 1'b1, 2'(id - 4), (id <= 5) ? b : off[2:0], a, d};
    else if (id >= 8 && id <= 11)  w = {(id <= 9) ? 4'h2 : 4'h3, 1'(id % 2), d, off[7:0]};
    else if (id >= 12 && id <= 27) w = {4'h4, 4'((id - 12) / 4), 2'((id - 12) % 4), b, d};
    else if (id >= 28 && id <= 30) w = {8'h44, 2'(id - 27), b, d};
    else if (id >= 31 && id <= 33) w = {8'h45, 2'(id - 30), b, d};
    else if (id >= 34 && id <= 37) w = {8'h46, 2'(id - 34), b, d};
    else if (id == 38)             w = {8'h47, c[3:0], 1'b0, b};
    else if (id == 76)             w = {8'h47, 4'hF, 1'b0, b};
    else if (id == 39)             w = {4'h4, 1'b1, d, off[7:0]};
    else if (id >= 40 && id <= 47) w = {4'h5, 3'(id - 40), b, a, d};
    else if (id >= 48 && id <= 53) w = {4'(6 + (id - 48) / 2), 1'(id % 2), off[4:0], a, d};
    else if (id >= 54 && id <= 57) w = {4'(9 + (id - 54) / 2), 1'(id % 2), d, off[7:0]};
    else if (id == 58)             w = 16'hB000;
    else if (id >= 59 && id <= 62) w = {8'hB2, 2'(id - 59), b, d};
    else if (id >= 63 && id <= 66) w = {8'hBA, 2'(id - 63), b, d};
    else if (id == 67)             w = {8'hB4, 5'b0, d};
    else if (id == 68)             w = {8'hBD, 5'b0, d};
    else if (id == 69)             w = {8'hBE, 5'b0, d};
    else if (id == 70)             w = 16'hBE40;
    else if (id == 71)             w = {8'hBE, 2'b10, 3'b0, d};
    else if (id == 72)             w = 16'hC000;
    else if (id == 73)             w = {4'hD, c[3:0], off[7:0]};
    else if (id == 74)             w = 16'hE000;
    else if (id == 75)             w = 16'hE800;
    else if (id == 100)            w = 16'hFFFF;
    else                           v = 1'b0;
    return {v, w};
  endfunction

  task automatic step();
    wr_t e;
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mem_we", 32'(mem_we), 1);
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      chk("mem_data", 32'(mem_data), 32'(e.data));
      chk("word_count", 32'(word_count), 32'(e.count));
    end else begin
      chk("mem_we_quiet", 32'(mem_we), 0);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] exp);
    chk(tag, 32'({in_ready, busy, done, error}), 32'(exp));
  endtask

  task automatic do_start(input logic [10:0] base);
    start = 1'b1; base_addr = base;
    exp_addr = base; exp_count = '0;
    step();
    start = 1'b0;
    chk_st("start_run", 4'b1100);
    chk("start_count", 32'(word_count), 0);
  endtask

  // exp_w = {encodable, word}; a non-encodable bundle queues no write.
  task automatic send(input int id, input logic [3:0] rd, ra, rb, input logic [11:0] off,
                      input logic [4:0] c, input logic [16:0] exp_w);
    chk("in_ready", 32'(in_ready), 1);
    ID = 7'(id); RegD = rd; RegA = ra; RegB = rb; Offset = off; branch_condition = c;
    in_valid = 1'b1;
    if (exp_w[16]) begin
      sb.push_back('{exp_addr, exp_w[15:0], 12'(exp_count + 12'd1)});
      exp_addr++;
      exp_count++;
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int bad_ids[6] = '{0, 77, 78, 99, 101, 127};
    logic [3:0]  rd, ra, rb;
    logic [11:0] off;
    logic [4:0]  c;

    step();
    step();
    chk_st("reset_status", 4'b0000);
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_data", 32'(mem_data), 0);
    chk("reset_count", 32'(word_count), 0);
    reset = 1'b0;
    step();
    chk_st("idle_status", 4'b0000);

    do_start(11'h010);
    send(40, 4'd1, 4'd2, 4'd3, 12'h000, 5'h00, {1'b1, 16'h50D1});

    do_start(11'h010);
    send(73, 4'd0, 4'd0, 4'd0, 12'h005, 5'h00, {1'b1, 16'hD005});
    send(72, 4'd0, 4'd0, 4'd0, 12'h000, 5'h00, {1'b1, 16'hC000});
    send(38, 4'd0, 4'd0, 4'd5, 12'h000, 5'h1F, {1'b1, 16'h47F5});
    send(76, 4'd0, 4'd0, 4'd5, 12'h000, 5'h00, {1'b1, 16'h47F5});
    send(73, 4'd0, 4'd0, 4'd0, 12'h012, {1'b0, COND_ALWAYS}, {1'b1, 16'hDE12});

    for (int id = 1; id <= 100; id++) begin
      if (id <= 76 || id == 100) begin
        rd = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
        off = 12'($urandom); c = 5'($urandom);
        send(id, rd, ra, rb, off, c, ref_enc(id, rd, ra, rb, off, c));
      end
    end
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk_st("finish_done", 4'b0010);
    chk("finish_count", 32'(word_count), 32'(exp_count));

    do_start(11'h020);
    foreach (bad_ids[i]) begin
      send(74, 4'd0, 4'd0, 4'd0, 12'h000, 5'h00, ref_enc(74, 4'd0, 4'd0, 4'd0, 12'h000, 5'h00));
      send(bad_ids[i], 4'd7, 4'd7, 4'd7, 12'hFFF, 5'h1F,
           ref_enc(bad_ids[i], 4'd7, 4'd7, 4'd7, 12'hFFF, 5'h1F));
      chk_st("bad_id_error", 4'b0001);
      do_start(11'h020);
    end

    do_start(11'h7FF);
    send(74, 4'd0, 4'd0, 4'd0, 12'h000, 5'h00, {1'b1, 16'hE000});
    chk_st("full_status", 4'b0100);
    ID = 7'd72; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_st("full_hold", 4'b0100);
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk_st("full_done", 4'b0010);
    chk("full_count", 32'(word_count), 1);

    do_start(11'h100);
    finish = 1'b1;
    send(1, 4'd3, 4'd4, 4'd0, 12'h01F, 5'h00, {1'b1, 16'h07E3});
    finish = 1'b0;
    chk_st("accept_finish_done", 4'b0010);
    chk("accept_finish_count", 32'(word_count), 1);

    do_start(11'h050);
    send(40, 4'd1, 4'd2, 4'd3, 12'h000, 5'h00, {1'b1, 16'h50D1});
    ID = 7'd72; in_valid = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("async_we", 32'(mem_we), 0);
    chk_st("async_status", 4'b0000);
    chk("async_addr", 32'(mem_addr), 0);
    chk("async_data", 32'(mem_data), 0);
    chk("async_count", 32'(word_count), 0);
    in_valid = 1'b0;
    step();
    #3 reset = 1'b0;
    step();
    chk_st("post_reset_idle", 4'b0000);
    chk("post_reset_sb", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
